sys_bus_arb: RTL

SYS_BUS_ARB -- requirements
Module: sys_bus_arb

---
 rtl/sys_bus_arb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sys_bus_arb.sv
// Two-master arbiter in front of a single APB-style slave, with an ACCESS-phase timeout.
// Optional: define SYS_BUS_ARB_RR_EN for round-robin arbitration (default: fixed priority, m0 first).
module sys_bus_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  pclk,
   input  logic                  prst,
   input  logic                  m0_req,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_write,
   input  logic [3:0]            m0_stb,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ready,
   output logic                  m0_err,
   input  logic                  m1_req,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_write,
   input  logic [3:0]            m1_stb,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ready,
   output logic                  m1_err,
   output logic [ADDR_WIDTH-1:0] s_paddr,
   output logic [DATA_WIDTH-1:0] s_pdata,
   output logic                  s_pwrite,
   output logic [3:0]            s_pstb,
   output logic                  s_psel,
   output logic                  s_penable,
   input  logic [DATA_WIDTH-1:0] s_prdata,
   input  logic                  s_pready,
   input  logic                  s_perr
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t                  state_q;
   logic                    gnt_q;
   logic                    gnt_d;
   logic [CW-1:0]           cnt_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [DATA_WIDTH-1:0]   pdata_q;
   logic                    pwrite_q;
   logic [3:0]              pstb_q;
   logic                    psel_q;
   logic                    penable_q;
   logic [DATA_WIDTH-1:0]   rdata0_q;
   logic [DATA_WIDTH-1:0]   rdata1_q;
   logic                    ready0_q;
   logic                    ready1_q;
   logic                    err0_q;
   logic                    err1_q;
   logic                    fin_d;
   logic                    rsp_err_d;
   logic [DATA_WIDTH-1:0]   rsp_data_d;
`ifdef SYS_BUS_ARB_RR_EN
   logic                    last_q;
`endif

   // Winner selection among requests seen in IDLE
   always_comb begin
      gnt_d = 1'b0;
      if (m0_req && m1_req) begin
`ifdef SYS_BUS_ARB_RR_EN
         gnt_d = ~last_q;
`else
         gnt_d = 1'b0;
`endif
      end else if (m1_req) begin
         gnt_d = 1'b1;
      end else begin
         gnt_d = 1'b0;
      end
   end

   // ACCESS completion: slave response wins over a timeout in the same cycle
   always_comb begin
      fin_d      = 1'b0;
      rsp_err_d  = 1'b1;
      rsp_data_d = '0;
      if (s_pready) begin
         fin_d      = 1'b1;
         rsp_err_d  = s_perr;
         rsp_data_d = s_prdata;
      end else begin
         fin_d      = (cnt_q == CNT_LAST);
         rsp_err_d  = 1'b1;
         rsp_data_d = '0;
      end
   end

   // Transfer FSM with registered slave-side and master-side outputs
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         cnt_q     <= '0;
         paddr_q   <= '0;
         pdata_q   <= '0;
         pwrite_q  <= 1'b0;
         pstb_q    <= 4'h0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         ready0_q  <= 1'b0;
         ready1_q  <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
`ifdef SYS_BUS_ARB_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_req || m1_req) begin
                  gnt_q    <= gnt_d;
                  paddr_q  <= gnt_d ? m1_addr  : m0_addr;
                  pdata_q  <= gnt_d ? m1_wdata : m0_wdata;
                  pwrite_q <= gnt_d ? m1_write : m0_write;
                  pstb_q   <= gnt_d ? m1_stb   : m0_stb;
                  psel_q   <= 1'b1;
`ifdef SYS_BUS_ARB_RR_EN
                  last_q   <= gnt_d;
`endif
                  state_q  <= SETUP;
               end else begin
                  state_q  <= IDLE;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (fin_d) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  if (gnt_q) begin
                     ready1_q <= 1'b1;
                     err1_q   <= rsp_err_d;
                     rdata1_q <= rsp_data_d;
                  end else begin
                     ready0_q <= 1'b1;
                     err0_q   <= rsp_err_d;
                     rdata0_q <= rsp_data_d;
                  end
                  state_q   <= DONE;
               end else begin
                  cnt_q     <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  state_q   <= ACCESS;
               end
            end
            DONE: begin
               ready0_q <= 1'b0;
               ready1_q <= 1'b0;
               err0_q   <= 1'b0;
               err1_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign s_paddr   = paddr_q;
   assign s_pdata   = pdata_q;
   assign s_pwrite  = pwrite_q;
   assign s_pstb    = pstb_q;
   assign s_psel    = psel_q;
   assign s_penable = penable_q;
   assign m0_rdata  = rdata0_q;
   assign m0_ready  = ready0_q;
   assign m0_err    = err0_q;
   assign m1_rdata  = rdata1_q;
   assign m1_ready  = ready1_q;
   assign m1_err    = err1_q;

endmodule
